dbus_arbiter: RTL and testbench
===============================

// Module: dbus_arbiter
// PURPOSE
//  Shares the single data-side bus (RAM plus I/O space) between the CPU data port and one DMA master.
//  Decodes each access to RAM or I/O, sequences I/O wait states and returns read data with an rvalid strobe.
//  Sits between cpu/dma and memory/iosystem; replaces the glue decode and read mux in the test systems.
// PARAMETERS
//  RAMADDRBASE  16'h2000  addresses >= this go to RAM, below go to I/O
//  IO_WAIT      2         extra wait cycles on an I/O read (0..7)
//  DMA_PRIO     0         1: DMA always wins a tie; 0: round-robin
// PORTS
//  clk            in   1   system clock, all state on posedge
//  reset          in   1   asynchronous reset, active-low (asserted when 0)
//  cpu_req        in   1   CPU access request, held until cpu_gnt
//  cpu_we         in   2   byte write enables; 2'b00 = read
//  cpu_addr       in   16  CPU byte address
//  cpu_wdata      in   16  CPU write data
//  cpu_gnt        out  1   access accepted this cycle
//  cpu_rvalid     out  1   cpu_rdata valid (1-cycle pulse)
//  cpu_rdata      out  16  read data
//  dma_*          -    -   identical set for the DMA master (req/we/addr/wdata/gnt/rvalid/rdata)
//  mem_dread_addr / mem_dwrite_addr  out 16; mem_dwrite_data out 16; mem_dwrite_en out 2; mem_dread_data in 16
//  io_dread_addr / io_dwrite_addr    out 16; io_dwrite_data out 16;  io_dwrite_en out 2;  io_dread_data in 16
// BEHAVIOUR
//  - Reset values: all gnt/rvalid 0, rdata 16'h0000, all *_dwrite_en 2'b00, addresses 0, FSM IDLE, rr pointer = CPU.
//  - Handshake: a transfer happens on req&&gnt. gnt is combinational from the FSM state and the requests.
//    gnt is only asserted in IDLE (or in RD_MEM, see below), and to at most one master.
//  - Arbitration: with DMA_PRIO=0, a tie goes to the master not granted last; the pointer updates on each grant.
//    A lone requester is always granted.
//  - Write: completes in the grant cycle. *_dwrite_en = we, steered by addr >= RAMADDRBASE. The other space gets 2'b00.
//    No rvalid is issued for a write.
//  - Read, RAM: dread_addr is driven in the grant cycle; FSM -> RD_MEM. The next cycle returns mem_dread_data.
//    rvalid is asserted to the owner. Latency = 1.
//    In RD_MEM a new request may be granted (back-to-back), giving 1 read per cycle.
//  - Read, I/O: io_dread_addr is held from the grant cycle; FSM -> RD_IO. The wait counter loads IO_WAIT.
//    No grants are issued while in RD_IO. At count 0, io_dread_data is captured to the owner and rvalid pulses; FSM -> IDLE.
//    Latency = IO_WAIT+1.
//  - rdata holds its last value between rvalid pulses. The non-owner's rdata is unchanged.
//  - FSM: IDLE -> RD_MEM | RD_IO | IDLE(write). RD_MEM -> RD_MEM | RD_IO | IDLE. RD_IO -> RD_IO (count>0) | IDLE.
//  - Decode uses the registered owner/space tag, never the live address, for read-data steering.
//  - Boundary: addr == RAMADDRBASE is RAM; RAMADDRBASE-1 is I/O. Address 16'hFFFF is RAM.
//  - A request dropped before gnt is a protocol violation; the block ignores it and does not hang.
//  - Reset asserted mid-read: the read is discarded, no rvalid is issued, and the block is in IDLE on release.
// STRUCTURE
//  - Package dbus_pkg: typedef enum {IDLE, RD_MEM, RD_IO} dbus_state_t; typedef enum {OWN_CPU, OWN_DMA} dbus_owner_t.
//    Also holds the RAMADDRBASE default constant.
//  - One sub-module, dbus_rr_arb: a 2-way round-robin/priority arbiter (req[1:0], prio, advance -> gnt[1:0]).
// TESTING
//  1. CPU write of 16'hBEEF at 16'h2000 with we=2'b11: mem_dwrite_en=11 in the gnt cycle, io_dwrite_en=00.
//     A CPU read of 16'h2000 then gives cpu_rvalid 1 cycle after gnt, with rdata=16'hBEEF.
//  2. CPU read at 16'h1FFE with IO_WAIT=2: io_dread_addr=16'h1FFE is held for 3 cycles.
//     cpu_rvalid pulses 3 cycles after gnt, and dma_gnt stays 0 throughout even though dma_req=1.
//  3. cpu_req and dma_req held high with RAM reads: grants alternate CPU, DMA, CPU...
//     Each gets rvalid on consecutive cycles. With DMA_PRIO=1, DMA gets every grant.
//  4. Back-to-back RAM reads 16'h2000, 16'h2002 by the CPU: 2 grants in 2 cycles.
//     rvalid appears in the following 2 cycles in order with the correct data.
//  5. Reset driven 0 during RD_IO: no rvalid is issued, all outputs return to reset values asynchronously.
//     The first request after release is granted in IDLE.
//  6. DMA byte write we=2'b01 at 16'h0010: io_dwrite_en=01, mem_dwrite_en=00, and no rvalid is issued.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter.
//   dbus_state_t : arbiter FSM states
//   dbus_owner_t : which master owns the read in flight
//   dbus_req_t   : one master's access request (we/addr/wdata)
package dbus_pkg;

  typedef enum logic [1:0] {IDLE, RD_MEM, RD_IO} dbus_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} dbus_owner_t;

  typedef struct packed {
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } dbus_req_t;

  localparam logic [15:0] RAMADDRBASE_DEF = 16'h2000;

endpackage

// File: rtl/dbus_rr_arb.sv
// Two-way arbiter, index 0 = CPU, index 1 = DMA.
//   req     : live requests
//   prio    : 1 -> DMA always wins a tie, 0 -> round-robin
//   advance : a grant was taken this cycle, move the tie-break pointer
//   gnt     : one-hot (or zero) grant, combinational from req
module dbus_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       advance,
  output logic [1:0] gnt
);

  // fav_q: master that wins the next tie (0 = CPU, 1 = DMA)
  logic fav_q, fav_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (prio || fav_q) ? 2'b10 : 2'b01;
    fav_d = fav_q;
    // The master just served loses the next tie.
    if (advance) fav_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fav_q <= 1'b0;
    else        fav_q <= fav_d;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the data-side bus (RAM + I/O) between the CPU data port and a DMA
// master. Decodes RAM vs I/O by address, sequences I/O read wait states and
// returns read data with a one-cycle rvalid strobe to the owning master.
//   clk, reset             : clock, async active-low reset
//   cpu_* / dma_*          : req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_*                  : RAM read address/data, write address/data/enable
//   io_*                   : I/O read address/data, write address/data/enable
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter logic [15:0] RAMADDRBASE = RAMADDRBASE_DEF,
  parameter int unsigned IO_WAIT     = 2,
  parameter bit          DMA_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [1:0]  dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_dread_addr,
  output logic [15:0] mem_dwrite_addr,
  output logic [15:0] mem_dwrite_data,
  output logic [1:0]  mem_dwrite_en,
  input  logic [15:0] mem_dread_data,
  output logic [15:0] io_dread_addr,
  output logic [15:0] io_dwrite_addr,
  output logic [15:0] io_dwrite_data,
  output logic [1:0]  io_dwrite_en,
  input  logic [15:0] io_dread_data
);

  localparam logic [2:0] IO_WAIT_C = IO_WAIT[2:0];

  dbus_state_t state_q, state_d;
  dbus_owner_t owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] io_addr_q, io_addr_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dma_rdata_q, dma_rdata_d;

  dbus_req_t   cpu_r, dma_r, sel_r;
  logic [1:0]  arb_gnt, gnt;
  logic        can_grant, sel_ram, rd_go, wr_go;
  logic        rsp_vld;
  logic [15:0] rsp_data;

  dbus_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     ({dma_req, cpu_req}),
    .prio    (DMA_PRIO),
    .advance (|gnt),
    .gnt     (arb_gnt)
  );

  // Request decode for the granted master
  always_comb begin
    cpu_r     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    dma_r     = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    // No grants while an I/O read is waiting, nor while reset is held.
    can_grant = reset && (state_q != RD_IO);
    gnt       = can_grant ? arb_gnt : 2'b00;
    sel_r     = gnt[1] ? dma_r : cpu_r;
    sel_ram   = (sel_r.addr >= RAMADDRBASE);
    rd_go     = (|gnt) && (sel_r.we == 2'b00);
    wr_go     = (|gnt) && (sel_r.we != 2'b00);
  end

  assign cpu_gnt = gnt[0];
  assign dma_gnt = gnt[1];

  // Bus-side outputs: writes complete in the grant cycle; the idle space sees zeros.
  always_comb begin
    mem_dwrite_en   = (wr_go &&  sel_ram) ? sel_r.we    : 2'b00;
    mem_dwrite_addr = (wr_go &&  sel_ram) ? sel_r.addr  : 16'h0000;
    mem_dwrite_data = (wr_go &&  sel_ram) ? sel_r.wdata : 16'h0000;
    io_dwrite_en    = (wr_go && !sel_ram) ? sel_r.we    : 2'b00;
    io_dwrite_addr  = (wr_go && !sel_ram) ? sel_r.addr  : 16'h0000;
    io_dwrite_data  = (wr_go && !sel_ram) ? sel_r.wdata : 16'h0000;
    mem_dread_addr  = (rd_go &&  sel_ram) ? sel_r.addr  : 16'h0000;
    // I/O read address is driven live in the grant cycle, then held until data returns.
    if (rd_go && !sel_ram)    io_dread_addr = sel_r.addr;
    else if (state_q == RD_IO) io_dread_addr = io_addr_q;
    else                       io_dread_addr = 16'h0000;
  end

  // Read return: steered by the registered state/owner, never the live address.
  always_comb begin
    rsp_vld     = (state_q == RD_MEM) || ((state_q == RD_IO) && (cnt_q == 3'd0));
    rsp_data    = (state_q == RD_MEM) ? mem_dread_data : io_dread_data;
    cpu_rvalid  = rsp_vld && (owner_q == OWN_CPU);
    dma_rvalid  = rsp_vld && (owner_q == OWN_DMA);
    cpu_rdata_d = cpu_rvalid ? rsp_data : cpu_rdata_q;
    dma_rdata_d = dma_rvalid ? rsp_data : dma_rdata_q;
  end

  // rdata shows returning data in the rvalid cycle and holds it afterwards.
  assign cpu_rdata = cpu_rdata_d;
  assign dma_rdata = dma_rdata_d;

  // Next state
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    io_addr_d = io_addr_q;
    if (state_q == RD_IO) begin
      if (cnt_q == 3'd0) state_d = IDLE;
      else               cnt_d   = cnt_q - 3'd1;
    end else begin
      // IDLE and RD_MEM both accept a new access (back-to-back RAM reads).
      state_d = IDLE;
      if (rd_go) begin
        owner_d = gnt[1] ? OWN_DMA : OWN_CPU;
        if (sel_ram) begin
          state_d = RD_MEM;
        end else begin
          state_d   = RD_IO;
          cnt_d     = IO_WAIT_C;
          io_addr_d = sel_r.addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= 3'd0;
      io_addr_q   <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      dma_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      io_addr_q   <= io_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios followed by random
// two-master traffic. Drivers push expected read responses into per-master
// queues; a monitor pops them on rvalid and also predicts every grant from the
// arbitration rules.
module tb_dbus_arbiter;
  localparam int          IO_WAIT = 2;
  localparam logic [15:0] RAMB    = 16'h2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, dma_req = 1'b0;
  logic [1:0]  cpu_we = 2'b00, dma_we = 2'b00;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0, dma_addr = 16'h0, dma_wdata = 16'h0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [15:0] cpu_rdata, dma_rdata;
  logic [15:0] mem_dread_addr, mem_dwrite_addr, mem_dwrite_data, io_dread_addr, io_dwrite_addr, io_dwrite_data;
  logic [1:0]  mem_dwrite_en, io_dwrite_en;
  logic [15:0] mem_dread_data = 16'h0, io_dread_data;

  // Second instance with DMA priority, sharing all inputs
  logic        p_cpu_gnt, p_cpu_rvalid, p_dma_gnt, p_dma_rvalid;
  logic [15:0] p_cpu_rdata, p_dma_rdata, p_mra, p_mwa, p_mwd, p_ira, p_iwa, p_iwd;
  logic [1:0]  p_mwe, p_iwe;

  dbus_arbiter #(.RAMADDRBASE(RAMB), .IO_WAIT(IO_WAIT), .DMA_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_dread_addr(mem_dread_addr), .mem_dwrite_addr(mem_dwrite_addr),
    .mem_dwrite_data(mem_dwrite_data), .mem_dwrite_en(mem_dwrite_en), .mem_dread_data(mem_dread_data),
    .io_dread_addr(io_dread_addr), .io_dwrite_addr(io_dwrite_addr),
    .io_dwrite_data(io_dwrite_data), .io_dwrite_en(io_dwrite_en), .io_dread_data(io_dread_data));

  dbus_arbiter #(.RAMADDRBASE(RAMB), .IO_WAIT(IO_WAIT), .DMA_PRIO(1'b1)) dut_p (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(p_cpu_gnt), .cpu_rvalid(p_cpu_rvalid), .cpu_rdata(p_cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(p_dma_gnt), .dma_rvalid(p_dma_rvalid), .dma_rdata(p_dma_rdata),
    .mem_dread_addr(p_mra), .mem_dwrite_addr(p_mwa),
    .mem_dwrite_data(p_mwd), .mem_dwrite_en(p_mwe), .mem_dread_data(mem_dread_data),
    .io_dread_addr(p_ira), .io_dwrite_addr(p_iwa),
    .io_dwrite_data(p_iwd), .io_dwrite_en(p_iwe), .io_dread_data(io_dread_data));

  int checks = 0, failures = 0, cyc = 0;
  bit chk_prio = 1'b0;

  typedef struct { logic [15:0] data; int due; } exp_t;
  exp_t q_cpu[$], q_dma[$];
  logic [15:0] ref_ram [logic [15:0]];
  logic [15:0] dev_ram [0:65535];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] init_fn(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] io_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h0F0F;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : init_fn(a);
  endfunction

  // Memory and I/O devices behind the bus
  assign io_dread_data = io_fn(io_dread_addr);
  initial begin
    for (int i = 0; i < 65536; i++) dev_ram[i] = init_fn(16'(i));
    forever begin
      @(posedge clk);
      mem_dread_data <= dev_ram[mem_dread_addr];
      if (mem_dwrite_en != 2'b00)
        dev_ram[mem_dwrite_addr] <= merge(dev_ram[mem_dwrite_addr], mem_dwrite_en, mem_dwrite_data);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_req(input int m, input logic r, input logic [1:0] we, input logic [15:0] a, input logic [15:0] wd);
    if (m == 0) begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    else        begin dma_req = r; dma_we = we; dma_addr = a; dma_wdata = wd; end
  endtask

  // Bus-side checks in the grant cycle
  task automatic chk_bus(input logic [1:0] we, input logic [15:0] a, input logic [15:0] wd);
    logic ram;
    ram = (a >= RAMB);
    if (we != 2'b00) begin
      chk("wr_mem_en", mem_dwrite_en, ram ? we : 2'b00);
      chk("wr_io_en", io_dwrite_en, ram ? 2'b00 : we);
      chk("wr_addr", ram ? mem_dwrite_addr : io_dwrite_addr, a);
      chk("wr_data", ram ? mem_dwrite_data : io_dwrite_data, wd);
    end else begin
      chk("rd_wen", {mem_dwrite_en, io_dwrite_en}, 4'b0000);
      if (ram) chk("rd_mem_addr", mem_dread_addr, a);
      else     chk("rd_io_addr", io_dread_addr, a);
    end
  endtask

  // One access by master m; returns the number of cycles spent waiting for gnt.
  task automatic access(input int m, input logic [1:0] we, input logic [15:0] a,
                        input logic [15:0] wd, output int waited);
    logic g;
    exp_t e;
    set_req(m, 1'b1, we, a, wd);
    g = 1'b0;
    waited = 0;
    while (!g && waited < 200) begin
      @(negedge clk);
      g = (m == 0) ? cpu_gnt : dma_gnt;
      waited++;
    end
    if (!g) begin
      chk(m == 0 ? "cpu_gnt_timeout" : "dma_gnt_timeout", 32'(g), 32'd1);
      @(posedge clk); #1;
      set_req(m, 1'b0, 2'b00, 16'h0, 16'h0);
    end else begin
      chk_bus(we, a, wd);
      if (we == 2'b00) begin
        e.due  = cyc + ((a >= RAMB) ? 1 : IO_WAIT + 1);
        e.data = (a >= RAMB) ? ref_rd(a) : io_fn(a);
        if (m == 0) q_cpu.push_back(e); else q_dma.push_back(e);
      end else if (a >= RAMB) begin
        ref_ram[a] = merge(ref_rd(a), we, wd);
      end
      @(posedge clk); #1;
      set_req(m, 1'b0, 2'b00, 16'h0, 16'h0);
      if (we == 2'b00 && a < RAMB)
        for (int k = 0; k < IO_WAIT + 1; k++) begin
          @(negedge clk);
          chk("io_addr_hold", io_dread_addr, a);
        end
    end
  endtask

  task automatic rand_driver(input int m, input int n);
    logic [1:0]  we;
    logic [15:0] a;
    int w;
    for (int i = 0; i < n; i++) begin
      we = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      case ($urandom_range(0, 5))
        0: a = RAMB + 16'($urandom_range(0, 31) * 2);
        1: a = 16'h1FC0 + 16'($urandom_range(0, 63));
        2: a = RAMB - 16'h1;
        3: a = RAMB;
        4: a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      access(m, we, a, 16'($urandom), w);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  // Monitor: predicts grants from the arbitration rules and scores read returns.
  initial begin
    logic [1:0]  eg;
    logic [15:0] lrd_cpu, lrd_dma;
    int  blk;
    bit  last_dma;
    exp_t e;
    blk = 0; last_dma = 1'b1; lrd_cpu = 16'h0; lrd_dma = 16'h0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        blk = 0; last_dma = 1'b1; lrd_cpu = 16'h0; lrd_dma = 16'h0;
      end else begin
        eg = 2'b00;
        if (blk == 0) begin
          if (cpu_req && dma_req) eg = last_dma ? 2'b01 : 2'b10;
          else                    eg = {dma_req, cpu_req};
        end
        chk("gnt", {dma_gnt, cpu_gnt}, eg);
        if (eg != 2'b00) begin
          last_dma = eg[1];
          if (eg[1] ? (dma_we == 2'b00 && dma_addr < RAMB) : (cpu_we == 2'b00 && cpu_addr < RAMB))
            blk = IO_WAIT + 1;
        end else if (blk > 0) begin
          blk--;
        end
        if (chk_prio && cpu_req && dma_req) chk("prio_dma_gnt", {p_dma_gnt, p_cpu_gnt}, 2'b10);
        // CPU return
        if (cpu_rvalid) begin
          if (q_cpu.size() == 0) chk("cpu_rvalid_extra", cpu_rvalid, 1'b0);
          else begin
            e = q_cpu.pop_front();
            chk("cpu_rvalid_cycle", cyc, e.due);
            chk("cpu_rdata", cpu_rdata, e.data);
            lrd_cpu = e.data;
          end
        end else begin
          chk("cpu_rdata_hold", cpu_rdata, lrd_cpu);
          if (q_cpu.size() > 0 && q_cpu[0].due < cyc) begin
            chk("cpu_rvalid_late", cyc, q_cpu[0].due);
            void'(q_cpu.pop_front());
          end
        end
        // DMA return
        if (dma_rvalid) begin
          if (q_dma.size() == 0) chk("dma_rvalid_extra", dma_rvalid, 1'b0);
          else begin
            e = q_dma.pop_front();
            chk("dma_rvalid_cycle", cyc, e.due);
            chk("dma_rdata", dma_rdata, e.data);
            lrd_dma = e.data;
          end
        end else begin
          chk("dma_rdata_hold", dma_rdata, lrd_dma);
          if (q_dma.size() > 0 && q_dma[0].due < cyc) begin
            chk("dma_rvalid_late", cyc, q_dma[0].due);
            void'(q_dma.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;
    // Reset state, with both requests raised to show gnt is held off
    cpu_req = 1'b1; dma_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {cpu_gnt, dma_gnt}, 2'b00);
    chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'h0);
    chk("rst_wen", {mem_dwrite_en, io_dwrite_en}, 4'b0000);
    chk("rst_addr", {mem_dread_addr, io_dread_addr}, 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0; reset = 1'b1;

    // Both masters streaming RAM reads: alternation, and DMA-priority instance
    chk_prio = 1'b1;
    fork
      for (int i = 0; i < 4; i++) access(0, 2'b00, 16'h2100 + 16'(2 * i), 16'h0, w);
      for (int i = 0; i < 4; i++) access(1, 2'b00, 16'h2200 + 16'(2 * i), 16'h0, w2);
    join
    chk_prio = 1'b0;

    // RAM write then read-back
    access(0, 2'b11, 16'h2000, 16'hBEEF, w);
    access(0, 2'b00, 16'h2000, 16'h0, w);
    // Back-to-back RAM reads
    access(0, 2'b00, 16'h2000, 16'h0, w);
    access(0, 2'b00, 16'h2002, 16'h0, w);
    chk("b2b_wait", w, 1);
    // DMA byte write to I/O
    access(1, 2'b01, 16'h0010, 16'h1234, w);
    // CPU I/O read at the boundary; DMA held off while it waits
    fork
      access(0, 2'b00, RAMB - 16'h2, 16'h0, w);
      begin @(posedge clk); #2; access(1, 2'b00, 16'h2010, 16'h0, w2); end
    join
    chk("dma_blocked_wait", w2, IO_WAIT + 2);
    access(1, 2'b00, 16'hFFFF, 16'h0, w);
    access(0, 2'b10, 16'hFFFF, 16'hA55A, w);
    access(1, 2'b00, 16'hFFFF, 16'h0, w);

    // Reset in the middle of an I/O read
    repeat (2) begin @(posedge clk); #1; end
    cpu_req = 1'b1; cpu_we = 2'b00; cpu_addr = 16'h0100;
    w = 0;
    do begin @(negedge clk); w++; end while (!cpu_gnt && w < 50);
    chk("rst_test_gnt", cpu_gnt, 1'b1);
    @(posedge clk); #1; cpu_req = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("arst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
    chk("arst_rdata", {cpu_rdata, dma_rdata}, 32'h0);
    chk("arst_io_addr", io_dread_addr, 16'h0);
    chk("arst_wen", {mem_dwrite_en, io_dwrite_en}, 4'b0000);
    q_cpu.delete();
    repeat (3) begin @(negedge clk); chk("arst_no_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00); end
    @(posedge clk); #1; reset = 1'b1;
    access(0, 2'b00, 16'h2004, 16'h0, w);
    chk("gnt_after_reset", w, 1);

    // Random two-master traffic
    fork
      rand_driver(0, 60);
      rand_driver(1, 60);
    join
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("cpu_queue_drained", q_cpu.size(), 0);
    chk("dma_queue_drained", q_dma.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
